// File: rtl/calc_pkg.sv
// calc_pkg: opcode and FSM state encodings shared by the calculator core and its iterative unit
package calc_pkg;
   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_e;
   typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_EXEC = 2'b01, ST_DONE = 2'b10} state_e;
endpackage

// File: rtl/calc_muldiv.sv
// calc_muldiv: MAG_W-step shift-add multiplier and restoring divider on unsigned magnitudes
module calc_muldiv
   import calc_pkg::*;
#(
   parameter int MAG_W = 4,
   parameter int OUT_W = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         load,
   input  logic                         step,
   input  op_e                          op,
   input  logic [MAG_W-1:0]             a,
   input  logic [MAG_W-1:0]             b,
   output logic [OUT_W-1:0]             res,
   output logic [$clog2(MAG_W+1)-1:0]   cnt
);
   logic [OUT_W-1:0] acc, bsh;
   logic [MAG_W-1:0] q;
   logic [MAG_W:0]   r_try, d;
   logic             divr, ge;
   // q holds the multiplier (shifted out) or the dividend (quotient shifted in)
   assign r_try = {acc[MAG_W-1:0], q[MAG_W-1]};
   assign d     = {1'b0, bsh[MAG_W-1:0]};
   assign ge    = r_try >= d;
   assign res   = divr ? OUT_W'(q) : acc;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         bsh  <= '0;
         q    <= '0;
         divr <= 1'b0;
         cnt  <= '0;
      end else if (load) begin
         acc  <= '0;
         bsh  <= OUT_W'(b);
         q    <= a;
         divr <= op == OP_DIV;
         cnt  <= '0;
      end else if (step) begin
         if (divr) begin
            acc <= OUT_W'(ge ? r_try - d : r_try);
            q   <= {q[MAG_W-2:0], ge};
         end else begin
            acc <= q[0] ? acc + bsh : acc;
            bsh <= bsh << 1;
            q   <= q >> 1;
         end
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/calc_core.sv
// calc_core: sign-magnitude add/sub/mul/div unit feeding the seven-segment display driver;
// results are registered on leaving DONE and held until the next accepted request.
module calc_core
   import calc_pkg::*;
#(
   parameter int MAG_W = 4,
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [MAG_W:0]   x,
   input  logic [MAG_W:0]   y,
   input  logic [1:0]       op,
   output logic [OUT_W-1:0] out,
   output logic             sign,
   output logic             err,
   output logic             busy,
   output logic             done
);
   localparam int CNT_W = $clog2(MAG_W + 1);
   state_e           state, state_n;
   op_e              opr;
   logic [MAG_W:0]   xr, yr;
   logic             start_d, accept, is_md, last, xs, ys, dz, as_sign, res_sign;
   logic [OUT_W-1:0] xm, ym, as_mag, md_res, res_mag;
   logic [CNT_W-1:0] cnt;
   assign accept = state == ST_IDLE && start && !start_d;
   assign is_md  = opr == OP_MUL || opr == OP_DIV;
   assign last   = cnt == CNT_W'(MAG_W - 1);
   assign xm     = OUT_W'(xr[MAG_W-1:0]);
   assign ym     = OUT_W'(yr[MAG_W-1:0]);
   assign xs     = xr[MAG_W];
   assign ys     = yr[MAG_W] ^ (opr == OP_SUB);
   assign dz     = opr == OP_DIV && ym == '0;
   // A zero magnitude forces a positive sign, which also absorbs -0 operands
   assign as_mag   = xs == ys ? xm + ym : (xm >= ym ? xm - ym : ym - xm);
   assign as_sign  = xs == ys ? xs : (xm >= ym ? xs : ys);
   assign res_mag  = is_md ? (dz ? '0 : md_res) : as_mag;
   assign res_sign = res_mag != '0 && (is_md ? xr[MAG_W] ^ yr[MAG_W] : as_sign);
   calc_muldiv #(.MAG_W(MAG_W), .OUT_W(OUT_W)) u_muldiv (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .step  (state == ST_EXEC),
      .op    (op_e'(op)),
      .a     (x[MAG_W-1:0]),
      .b     (y[MAG_W-1:0]),
      .res   (md_res),
      .cnt   (cnt)
   );
   always_comb begin
      state_n = state;
      state_n = state == ST_IDLE ? (accept ? ST_EXEC : ST_IDLE)
              : state == ST_EXEC ? ((!is_md || last) ? ST_DONE : ST_EXEC)
              : ST_IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         start_d <= 1'b0;
         xr      <= '0;
         yr      <= '0;
         opr     <= OP_ADD;
         out     <= '0;
         sign    <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         start_d <= start;
         busy    <= state_n == ST_EXEC;
         done    <= state == ST_DONE;
         if (accept) begin
            xr  <= x;
            yr  <= y;
            opr <= op_e'(op);
         end
         if (state == ST_DONE) begin
            out  <= res_mag;
            sign <= res_sign;
            err  <= dz;
         end
      end
   end
endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: directed and randomized checks of calc_core against a signed-integer model
module tb_calc_core;
   logic       clk = 0, rst_n = 0, start = 0;
   logic [4:0] x = 0, y = 0;
   logic [1:0] op = 0;
   logic [7:0] out;
   logic       sign, err, busy, done;
   int         total = 0, bad = 0;
   int         lat, bcnt, nd;
   logic       pulse_ok;
   logic [7:0] em;
   logic       es, ee;

   calc_core dut (.clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .op(op),
                  .out(out), .sign(sign), .err(err), .busy(busy), .done(done));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, o, e);
      end
   endtask

   // Issue one request with a clean rising edge; measure done latency and busy cycles
   task automatic do_op(input logic [4:0] a, input logic [4:0] b, input logic [1:0] o);
      @(negedge clk);
      x = a; y = b; op = o; start = 1;
      @(posedge clk); #1;
      bcnt = int'(busy);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (busy) bcnt++;
      end while (!done && lat < 20);
      start = 0;
      @(posedge clk); #1;
      pulse_ok = !done;
   endtask

   task automatic model(input logic [4:0] a, input logic [4:0] b, input logic [1:0] o);
      int av, bv, r;
      av = a[4] ? -int'(a[3:0]) : int'(a[3:0]);
      bv = b[4] ? -int'(b[3:0]) : int'(b[3:0]);
      ee = o == 2'b11 && bv == 0;
      r = o == 2'b00 ? av + bv : o == 2'b01 ? av - bv : o == 2'b10 ? av * bv : (ee ? 0 : av / bv);
      em = 8'(r < 0 ? -r : r);
      es = r < 0;
   endtask

   task automatic count_done(input int n);
      nd = 0;
      repeat (n) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_out", out, 0); chk("rst_sign", sign, 0); chk("rst_err", err, 0);
      chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      @(negedge clk) rst_n = 1;

      do_op(5'b00111, 5'b11100, 2'b00);
      chk("add_out", out, 5); chk("add_sign", sign, 1); chk("add_lat", lat, 2);
      chk("add_busy", bcnt, 1); chk("add_pulse", pulse_ok, 1);
      do_op(5'b01001, 5'b01001, 2'b01);
      chk("sub0_out", out, 0); chk("sub0_sign", sign, 0);

      do_op(5'b11111, 5'b01111, 2'b10);
      chk("mul_out", out, 225); chk("mul_sign", sign, 1); chk("mul_lat", lat, 5);
      chk("mul_busy", bcnt, 4); chk("mul_pulse", pulse_ok, 1);

      do_op(5'b11101, 5'b10100, 2'b11);
      chk("div_out", out, 3); chk("div_sign", sign, 0); chk("div_err", err, 0); chk("div_lat", lat, 5);
      do_op(5'b11101, 5'b00000, 2'b11);
      chk("dz_out", out, 0); chk("dz_sign", sign, 0); chk("dz_err", err, 1); chk("dz_lat", lat, 5);
      do_op(5'b00001, 5'b00010, 2'b00);
      chk("clr_out", out, 3); chk("clr_err", err, 0);

      do_op(5'b10000, 5'b00000, 2'b00);
      chk("negz_add_out", out, 0); chk("negz_add_sign", sign, 0);
      do_op(5'b10000, 5'b10011, 2'b10);
      chk("negz_mul_out", out, 0); chk("negz_mul_sign", sign, 0);

      @(negedge clk); x = 5'd3; y = 5'd3; op = 2'b10; start = 1;
      @(negedge clk) start = 0;
      @(negedge clk) start = 1;
      count_done(12);
      chk("busy_edge_dones", nd, 1); chk("busy_edge_out", out, 9);
      @(negedge clk) start = 0;

      @(negedge clk); x = 5'd2; y = 5'd3; op = 2'b00; start = 1;
      count_done(10);
      chk("held_dones", nd, 1); chk("held_out", out, 5);
      @(negedge clk) start = 0;

      @(negedge clk); x = 5'd5; y = 5'd3; op = 2'b10; start = 1;
      @(negedge clk); x = 5'd7; start = 0;
      count_done(8);
      chk("latch_dones", nd, 1); chk("latch_out", out, 15);

      @(negedge clk); x = 5'd15; y = 5'd15; op = 2'b10; start = 1;
      repeat (2) @(negedge clk);
      rst_n = 0; start = 0;
      #1;
      chk("midrst_out", out, 0); chk("midrst_sign", sign, 0); chk("midrst_err", err, 0);
      chk("midrst_busy", busy, 0); chk("midrst_done", done, 0);
      @(negedge clk) rst_n = 1;
      count_done(10);
      chk("midrst_nodone", nd, 0);

      for (int i = 0; i < 500; i++) begin
         logic [4:0] a, b;
         logic [1:0] o;
         a = 5'($urandom_range(0, 31));
         b = 5'($urandom_range(0, 31));
         o = 2'($urandom_range(0, 3));
         model(a, b, o);
         do_op(a, b, o);
         chk("rnd_out", out, em); chk("rnd_sign", sign, es); chk("rnd_err", err, ee);
         chk("rnd_lat", lat, o[1] ? 5 : 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
